// File: rtl/shift_frame_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module : shift_frame_ctrl_pkg
// Brief  : Shared state encoding and sizing helpers for the shift frame sequencer.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package shift_frame_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // GAP is at most 15, so the gap counter never needs more than 4 bits.
    localparam int c_GAP_W = 4;

    function automatic int sf_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/shift_frame_dp.sv
//------------------------------------------------------------------------------
// Module : shift_frame_dp
// Brief  : WIDTH-bit shift register with clear/load/shift, MSB serial out and
//          parallel tap of the value that the next shift would produce.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_frame_dp
    import shift_frame_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_si,
    output logic             o_msb,
    output logic [WIDTH-1:0] o_next
);

    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shifted;

    assign w_shifted = {r_shreg[WIDTH-2:0], i_si};
    assign o_msb     = r_shreg[WIDTH-1];
    assign o_next    = w_shifted;

    // Clear outranks load so an abort always leaves the register empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg <= '0;
        end else if (i_clear) begin
            r_shreg <= '0;
        end else if (i_load) begin
            r_shreg <= i_load_data;
        end else if (i_shift) begin
            r_shreg <= w_shifted;
        end
    end

endmodule

`default_nettype wire

// File: rtl/shift_frame_ctrl.sv
//------------------------------------------------------------------------------
// Module : shift_frame_ctrl
// Brief  : Frame sequencer: accepts a parallel word, shifts it MSB-first on SO
//          while capturing SI, then enforces an inter-frame gap.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_frame_ctrl
    import shift_frame_ctrl_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter int   GAP        = 1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ld_valid,
    output logic             o_ld_ready,
    input  logic [WIDTH-1:0] i_ld_data,
    input  logic             i_abort,
    input  logic             i_si,
    output logic             o_so,
    output logic             o_shift_en,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_rx_data,
    output logic             o_rx_valid
);

    localparam int                 CW         = sf_clog2(WIDTH);
    localparam logic [CW-1:0]      c_CNT_LAST = CW'(WIDTH - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic [1:0]         c_AFTER_SHIFT = (GAP > 0) ? ST_GAP : ST_IDLE;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [CW-1:0]      r_cnt;
    logic [c_GAP_W-1:0] r_gapcnt;
    logic               r_ld_ready;
    logic [WIDTH-1:0]   r_rx_data;
    logic               r_rx_valid;

    logic               w_in_shift;
    logic               w_accept;
    logic               w_last_shift;
    logic               w_dp_msb;
    logic [WIDTH-1:0]   w_dp_next;

    assign w_in_shift   = (r_state == ST_SHIFT);
    assign w_accept     = (r_state == ST_IDLE) && i_ld_valid && r_ld_ready && !i_abort;
    assign w_last_shift = w_in_shift && (r_cnt == c_CNT_LAST) && !i_abort;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (i_abort) begin
                    w_next_state = ST_IDLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_next_state = c_AFTER_SHIFT;
                end
            end
            ST_GAP: begin
                if (i_abort || (r_gapcnt == c_GAP_LAST)) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    shift_frame_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_in_shift && i_abort),
        .i_load      (w_accept),
        .i_shift     (w_in_shift && !i_abort),
        .i_load_data (i_ld_data),
        .i_si        (i_si),
        .o_msb       (w_dp_msb),
        .o_next      (w_dp_next)
    );

    // Counters restart at zero whenever their state is entered or left.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_gapcnt   <= '0;
            r_ld_ready <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_ld_ready <= (w_next_state == ST_IDLE);
            r_rx_valid <= w_last_shift;
            if (w_in_shift && (w_next_state == ST_SHIFT)) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            if ((r_state == ST_GAP) && (w_next_state == ST_GAP)) begin
                r_gapcnt <= r_gapcnt + 1'b1;
            end else begin
                r_gapcnt <= '0;
            end
            if (w_last_shift) begin
                r_rx_data <= w_dp_next;
            end
        end
    end

    assign o_ld_ready = r_ld_ready;
    assign o_so       = w_in_shift ? w_dp_msb : IDLE_LEVEL;
    assign o_shift_en = w_in_shift;
    assign o_busy     = (r_state != ST_IDLE);
    assign o_rx_data  = r_rx_data;
    assign o_rx_valid = r_rx_valid;

endmodule

`default_nettype wire

// File: tb/tb_shift_frame_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_shift_frame_ctrl
// Brief  : Scoreboard bench for shift_frame_ctrl (GAP=1 main DUT, GAP=0 spacing DUT).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_shift_frame_ctrl;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
        int         nbits;
        bit         aborted;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_ld_valid, i_abort, si_drv, lb;
    logic [7:0] i_ld_data;
    logic       o_ld_ready, o_so, o_shift_en, o_busy, o_rx_valid;
    logic [7:0] o_rx_data;
    logic       w_si;

    logic       rst0, valid0;
    logic [7:0] data0;
    logic       ready0, so0, shen0, busy0, rxv0, abort0;
    logic [7:0] rx0;

    exp_t       q[$];
    logic [7:0] q0[$];
    logic [7:0] exp_rx_last;
    int         epoch;
    int         cyc;
    int         n_checks;
    int         n_fail;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign w_si   = lb ? o_so : si_drv;
    assign abort0 = 1'b0;

    shift_frame_ctrl #(.WIDTH(8), .GAP(1), .IDLE_LEVEL(1'b0)) dut (
        .clk (clk), .rst (rst), .i_ld_valid (i_ld_valid), .o_ld_ready (o_ld_ready),
        .i_ld_data (i_ld_data), .i_abort (i_abort), .i_si (w_si), .o_so (o_so),
        .o_shift_en (o_shift_en), .o_busy (o_busy), .o_rx_data (o_rx_data),
        .o_rx_valid (o_rx_valid)
    );

    shift_frame_ctrl #(.WIDTH(8), .GAP(0), .IDLE_LEVEL(1'b0)) dut0 (
        .clk (clk), .rst (rst0), .i_ld_valid (valid0), .o_ld_ready (ready0),
        .i_ld_data (data0), .i_abort (abort0), .i_si (so0), .o_so (so0),
        .o_shift_en (shen0), .o_busy (busy0), .o_rx_data (rx0), .o_rx_valid (rxv0)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic wait_ready(output bit ok);
        int t;
        t = 0;
        while (!o_ld_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        ok = o_ld_ready;
        if (!ok) check("ready_timeout", {31'd0, o_ld_ready}, 32'd1);
    endtask

    // One frame: SI carries rxw MSB-first; abort_at selects the shift cycle to abort in (-1: none).
    task automatic do_frame(input logic [7:0] tx, input logic [7:0] rxw, input bit loopb,
                            input int abort_at);
        exp_t e;
        bit   ok;
        wait_ready(ok);
        if (!ok) return;
        lb         = loopb;
        i_ld_valid = 1'b1;
        i_ld_data  = tx;
        e.tx       = tx;
        e.rx       = loopb ? tx : rxw;
        e.aborted  = (abort_at >= 0);
        e.nbits    = (abort_at >= 0) ? abort_at + 1 : 8;
        q.push_back(e);
        @(posedge clk); #1;
        i_ld_data = 8'($urandom);
        for (int k = 0; k < 8; k++) begin
            si_drv     = rxw[7-k];
            i_ld_valid = 1'($urandom_range(0, 1));
            i_abort    = (k == abort_at);
            @(posedge clk); #1;
            i_abort = 1'b0;
            if (k == abort_at) break;
        end
        if (abort_at < 0) begin
            i_ld_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        i_ld_valid = 1'b0;
    endtask

    // Scoreboard monitor: gathers SO bits of each frame and checks at the first non-shift cycle.
    initial begin
        int         nb;
        int         my_ep;
        logic [31:0] w;
        logic [31:0] mask;
        exp_t       e;
        nb = 0; my_ep = 0; w = 0;
        forever begin
            @(negedge clk);
            if (epoch != my_ep) begin
                my_ep = epoch; nb = 0; w = 0;
            end
            if (rst) continue;
            if (o_shift_en) begin
                w = {w[30:0], o_so};
                nb++;
                check("rx_valid_during_shift", {31'd0, o_rx_valid}, 32'd0);
            end else begin
                check("so_idle_level", {31'd0, o_so}, 32'd0);
                if (nb > 0) begin
                    n_checks++;
                    if (q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_frame: got %0d bits with empty queue, required none", nb);
                    end else begin
                        e    = q.pop_front();
                        mask = (32'd1 << e.nbits) - 32'd1;
                        check("frame_bits", nb, e.nbits);
                        check("so_sequence", w & mask, 32'(e.tx) >> (8 - e.nbits));
                        check("rx_valid_pulse", {31'd0, o_rx_valid}, {31'd0, !e.aborted});
                        check("busy_after_frame", {31'd0, o_busy}, {31'd0, !e.aborted});
                        if (!e.aborted) exp_rx_last = e.rx;
                        check("rx_data", 32'(o_rx_data), 32'(exp_rx_last));
                    end
                    nb = 0; w = 0;
                end else begin
                    check("rx_valid_quiet", {31'd0, o_rx_valid}, 32'd0);
                end
            end
        end
    end

    // GAP=0 instance: LD_VALID held high, LD_DATA randomized every cycle, loopback.
    initial begin
        forever begin
            @(posedge clk); #1;
            data0 = 8'($urandom);
        end
    end

    initial begin
        int last_acc;
        last_acc = -1;
        forever begin
            @(negedge clk);
            if (rst0) continue;
            if (ready0 && valid0) begin
                if (last_acc >= 0) check("gap0_spacing", cyc - last_acc, 9);
                last_acc = cyc;
                q0.push_back(data0);
            end
            if (rxv0) begin
                n_checks++;
                if (q0.size() == 0) begin
                    n_fail++;
                    $display("FAIL gap0_unexpected_rx: got %0h with empty queue, required none", rx0);
                end else begin
                    logic [7:0] d;
                    d = q0.pop_front();
                    n_checks--;
                    check("gap0_rx_data", 32'(rx0), 32'(d));
                end
            end
        end
    end

    initial begin
        bit  ok;
        bit  rdy;
        int  t0;
        int  t;
        exp_t e;
        n_checks = 0; n_fail = 0; epoch = 0; cyc = 0; exp_rx_last = 8'h00;
        rst = 1'b1; rst0 = 1'b1; valid0 = 1'b0; data0 = 8'h00;
        i_ld_valid = 1'b0; i_abort = 1'b0; i_ld_data = 8'h00; si_drv = 1'b0; lb = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ld_ready", {31'd0, o_ld_ready}, 32'd0);
        check("reset_so", {31'd0, o_so}, 32'd0);
        check("reset_rx_data", 32'(o_rx_data), 32'd0);
        check("reset_busy", {31'd0, o_busy}, 32'd0);
        check("reset_shift_en", {31'd0, o_shift_en}, 32'd0);
        rst = 1'b0; rst0 = 1'b0;
        @(posedge clk); #1;
        check("ready_after_release", {31'd0, o_ld_ready}, 32'd1);
        valid0 = 1'b1;

        do_frame(8'hA5, 8'h00, 1'b1, -1);

        // Back-to-back with LD_VALID held: 0x3C then 0xC3, loopback.
        wait_ready(ok);
        lb = 1'b1; i_ld_valid = 1'b1; i_ld_data = 8'h3C;
        e.tx = 8'h3C; e.rx = 8'h3C; e.nbits = 8; e.aborted = 1'b0;
        q.push_back(e);
        @(posedge clk); #1;
        t0 = cyc;
        i_ld_data = 8'hC3;
        t = 0;
        do begin
            rdy = o_ld_ready;
            @(posedge clk); #1;
            t++;
        end while (!rdy && t < 30);
        check("b2b_spacing", cyc - t0, 10);
        e.tx = 8'hC3; e.rx = 8'hC3;
        q.push_back(e);
        i_ld_valid = 1'b0;

        do_frame(8'hFF, 8'h5A, 1'b0, 3);
        do_frame(8'hFF, 8'h96, 1'b0, 7);

        // ABORT in IDLE blocks an otherwise valid load.
        wait_ready(ok);
        i_abort = 1'b1; i_ld_valid = 1'b1; i_ld_data = 8'h77;
        @(posedge clk); #1;
        i_abort = 1'b0; i_ld_valid = 1'b0;
        check("idle_abort_busy", {31'd0, o_busy}, 32'd0);
        check("idle_abort_ready", {31'd0, o_ld_ready}, 32'd1);

        // Asynchronous reset between edges while shifting.
        wait_ready(ok);
        lb = 1'b1; i_ld_valid = 1'b1; i_ld_data = 8'hE7;
        @(posedge clk); #1;
        i_ld_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #1 rst = 1'b1;
        epoch++;
        #1;
        check("clr_so", {31'd0, o_so}, 32'd0);
        check("clr_shift_en", {31'd0, o_shift_en}, 32'd0);
        check("clr_busy", {31'd0, o_busy}, 32'd0);
        check("clr_ld_ready", {31'd0, o_ld_ready}, 32'd0);
        check("clr_rx_data", 32'(o_rx_data), 32'd0);
        exp_rx_last = 8'h00;
        rst = 1'b0;
        @(posedge clk); #1;
        check("clr_ready_after", {31'd0, o_ld_ready}, 32'd1);
        do_frame(8'h81, 8'h00, 1'b1, -1);

        for (int i = 0; i < 40; i++) begin
            do_frame(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1);
        end

        valid0 = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("main_queue_drained", q.size(), 0);
        check("gap0_queue_drained", q0.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
